address_generator: RTL and testbench
====================================

# address_generator

Weight/input address sequencer for the neuron datapath. It is the responder to the control unit's `AG_rst`/`AG_read` command lines. For each neuron it walks the input index 0..N_INPUTS-1 and the flat weight address, and it flags the end of each neuron and of the whole layer so the ALU and control unit can sequence accumulation. Outputs are registered and drive the input-memory and weight-memory read ports directly.

## Interface

- `N_INPUTS`, default 4, inputs per neuron; ≥1.
- `N_NEURONS`, default 3, neurons per layer; ≥1.
- `IN_W`, default 8, width of `in_addr`; 2^IN_W ≥ N_INPUTS.
- `N_W`, default 8, width of `neuron_idx`; 2^N_W ≥ N_NEURONS.
- `ADDR_W`, default 8, width of `w_addr`; 2^ADDR_W ≥ N_INPUTS*N_NEURONS.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `AG_rst`  in  1  synchronous, active-high clear from the control unit; same effect as `reset`.
- `AG_read`  in  1  advance enable; one address beat is issued per cycle while high.
- `in_addr`  out  IN_W  input-memory address of the current beat.
- `w_addr`  out  ADDR_W  weight-memory address, equal to neuron_idx*N_INPUTS + in_addr.
- `neuron_idx`  out  N_W  neuron of the current beat.
- `addr_valid`  out  1  the addresses are a new beat this cycle.
- `last_in`  out  1  the beat is the last input of its neuron; qualified by `addr_valid`.
- `last_neuron`  out  1  the beat belongs to neuron N_NEURONS-1; qualified by `addr_valid`.
- `busy`  out  1  state is RUN.
- `done`  out  1  the layer sweep is complete; sticky.

## Operation

- States: IDLE, RUN, DONE. Internal counters: `in_cnt`, `n_cnt`, `w_cnt`.
- Clear condition is `reset | AG_rst`. On clear, at the next edge:
  - state goes to IDLE;
  - all counters go to 0;
  - all outputs go to 0, including addresses, flags, `busy` and `done`.
- Clear takes priority over `AG_read` in the same cycle.
- Issue rule: on an edge with no clear, `AG_read=1` and state ≠ DONE:
  - `in_addr`←`in_cnt`, `neuron_idx`←`n_cnt`, `w_addr`←`w_cnt`;
  - `addr_valid`←1;
  - `last_in`←(`in_cnt`==N_INPUTS-1);
  - `last_neuron`←(`n_cnt`==N_NEURONS-1).
- Counter update on an issue:
  - `w_cnt` increments by 1. No multiplier is used; the equality with neuron_idx*N_INPUTS+in_addr holds by construction.
  - `in_cnt` increments, or wraps to 0 when it equals N_INPUTS-1. On that wrap `n_cnt` increments.
- IDLE→RUN on the first issue.
- RUN→DONE on the issue with `in_cnt`==N_INPUTS-1 and `n_cnt`==N_NEURONS-1. Counters do not advance past this beat.
- In DONE:
  - `AG_read` is ignored;
  - `addr_valid`←0 and `done`=1 until clear;
  - addresses hold the final beat (N_INPUTS-1, N_NEURONS-1, N_INPUTS*N_NEURONS-1).
- With `AG_read=0` and no clear, `addr_valid`←0, `last_in`/`last_neuron`←0, and addresses and counters hold. A stall can occur anywhere, including mid-neuron.
- N_INPUTS=1: every beat has `last_in`=1. N_NEURONS=1: every beat has `last_neuron`=1. N_INPUTS=N_NEURONS=1: the first issue goes IDLE→DONE directly, and `busy` never asserts.

## Timing

- Latency is 1 cycle: `AG_read` sampled high at edge k puts the beat on the outputs during cycle k..k+1.
- Throughput is one beat per cycle while `AG_read` is held high. N_INPUTS*N_NEURONS consecutive beats complete the layer with no bubbles.
- `done` rises at the same edge as the final beat's `addr_valid`. Both are high for that one cycle; after it `addr_valid`=0 and `done`=1.
- `busy` goes 1 at the edge issuing the first beat and 0 at the edge issuing the final beat.
- Clear mid-sweep: outputs are 0 one edge later. The next sweep restarts from beat 0, with no residual counter state.
- The power-up value is undefined until the first `reset`; the bench asserts `reset` for ≥1 cycle first.

## Test plan

- Reset: hold `reset=1` with `AG_read=1` for 2 cycles → all outputs 0. `AG_read` has no effect while `reset` is high.
- Full sweep, defaults (4×3), with `AG_read` held high:
  - 12 consecutive valid beats; `w_addr` runs 0..11, `in_addr` runs 0,1,2,3 repeating, `neuron_idx` runs 0,0,0,0,1,…,2;
  - `last_in` is high on beats 3, 7 and 11; `last_neuron` is high on beats 8–11;
  - `done` rises with beat 11; afterwards `addr_valid`=0 and addresses hold 3/2/11.
- Stall: assert `AG_read` for 2 cycles, drop it for 3, then resume → beats 0,1, then 3 cycles with `addr_valid`=0 and addresses holding 1/0/1, then beat 2 with `w_addr`=2; the total is still 12 beats.
- Clear mid-sweep: pulse `AG_rst` in the same cycle as `AG_read` after beat 5 → outputs are 0 next cycle. Resuming with `AG_read` restarts at `w_addr`=0, and `done` only rises after 12 fresh beats.
- DONE hold: after completion, drive `AG_read=1` for 5 cycles → no valid beats and `done` stays 1. Then `AG_rst` → `done`=0 and state is IDLE.
- Degenerate parameters N_INPUTS=1, N_NEURONS=1 → a single beat with `last_in`=`last_neuron`=1 and `done` rising with it, `busy` never asserting.

Source files
------------

// File: rtl/address_generator.sv
`default_nettype none
// ============================================================================
// Module   : address_generator
// Brief    : Weight/input address sequencer for the neuron datapath. Walks
//            the input index and flat weight address for every neuron of a
//            layer, flagging the last input of each neuron and the last
//            neuron of the layer. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module address_generator #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 3,
  parameter int IN_W      = 8,
  parameter int N_W       = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AG_rst,
  input  logic              AG_read,
  output logic [IN_W-1:0]   in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [N_W-1:0]    neuron_idx,
  output logic              addr_valid,
  output logic              last_in,
  output logic              last_neuron,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0] c_IN_LAST = IN_W'(N_INPUTS - 1);
  localparam logic [N_W-1:0]  c_N_LAST  = N_W'(N_NEURONS - 1);

  state_t             r_state,       w_state_nxt;
  logic [IN_W-1:0]    r_in_cnt,      w_in_cnt_nxt;
  logic [N_W-1:0]     r_n_cnt,       w_n_cnt_nxt;
  logic [ADDR_W-1:0]  r_w_cnt,       w_w_cnt_nxt;
  logic [IN_W-1:0]    r_in_addr,     w_in_addr_nxt;
  logic [N_W-1:0]     r_neuron_idx,  w_neuron_idx_nxt;
  logic [ADDR_W-1:0]  r_w_addr,      w_w_addr_nxt;
  logic               r_addr_valid,  w_addr_valid_nxt;
  logic               r_last_in,     w_last_in_nxt;
  logic               r_last_neuron, w_last_neuron_nxt;

  logic w_clear;
  logic w_issue;
  logic w_in_last;
  logic w_n_last;

  assign w_clear   = reset | AG_rst;
  assign w_issue   = AG_read && (r_state != S_DONE);
  assign w_in_last = (r_in_cnt == c_IN_LAST);
  assign w_n_last  = (r_n_cnt == c_N_LAST);

  // Next-state, counter and output-register logic; holds everything except
  // the per-beat strobes unless a clear or an issue occurs.
  always_comb begin
    w_state_nxt       = r_state;
    w_in_cnt_nxt      = r_in_cnt;
    w_n_cnt_nxt       = r_n_cnt;
    w_w_cnt_nxt       = r_w_cnt;
    w_in_addr_nxt     = r_in_addr;
    w_neuron_idx_nxt  = r_neuron_idx;
    w_w_addr_nxt      = r_w_addr;
    w_addr_valid_nxt  = 1'b0;
    w_last_in_nxt     = 1'b0;
    w_last_neuron_nxt = 1'b0;

    if (w_clear) begin
      w_state_nxt      = S_IDLE;
      w_in_cnt_nxt     = '0;
      w_n_cnt_nxt      = '0;
      w_w_cnt_nxt      = '0;
      w_in_addr_nxt    = '0;
      w_neuron_idx_nxt = '0;
      w_w_addr_nxt     = '0;
    end else if (w_issue) begin
      w_in_addr_nxt     = r_in_cnt;
      w_neuron_idx_nxt  = r_n_cnt;
      w_w_addr_nxt      = r_w_cnt;
      w_addr_valid_nxt  = 1'b1;
      w_last_in_nxt     = w_in_last;
      w_last_neuron_nxt = w_n_last;
      if (w_in_last && w_n_last) begin
        // Final beat of the layer: counters freeze on it.
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_RUN;
        // Weight address tracks neuron*N_INPUTS+input by plain counting.
        w_w_cnt_nxt = r_w_cnt + ADDR_W'(1);
        if (w_in_last) begin
          w_in_cnt_nxt = '0;
          w_n_cnt_nxt  = r_n_cnt + N_W'(1);
        end else begin
          w_in_cnt_nxt = r_in_cnt + IN_W'(1);
        end
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    r_state       <= w_state_nxt;
    r_in_cnt      <= w_in_cnt_nxt;
    r_n_cnt       <= w_n_cnt_nxt;
    r_w_cnt       <= w_w_cnt_nxt;
    r_in_addr     <= w_in_addr_nxt;
    r_neuron_idx  <= w_neuron_idx_nxt;
    r_w_addr      <= w_w_addr_nxt;
    r_addr_valid  <= w_addr_valid_nxt;
    r_last_in     <= w_last_in_nxt;
    r_last_neuron <= w_last_neuron_nxt;
  end

  assign in_addr     = r_in_addr;
  assign w_addr      = r_w_addr;
  assign neuron_idx  = r_neuron_idx;
  assign addr_valid  = r_addr_valid;
  assign last_in     = r_last_in;
  assign last_neuron = r_last_neuron;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_address_generator
// Brief    : Self-checking bench for address_generator: a beat-count model
//            checked every cycle, plus directed literal checks, and a
//            second instance with a single input and single neuron.
// Revision : 1.0 - initial release
// ============================================================================
module tb_address_generator;

  localparam int NI    = 4;
  localparam int NN    = 3;
  localparam int TOTAL = NI * NN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic AG_rst = 1'b0;
  logic AG_read = 1'b0;
  logic [7:0] in_addr, w_addr, neuron_idx;
  logic addr_valid, last_in, last_neuron, busy, done;

  logic AG_rst2 = 1'b0;
  logic AG_read2 = 1'b0;
  logic [7:0] in_addr2, w_addr2, neuron_idx2;
  logic addr_valid2, last_in2, last_neuron2, busy2, done2;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  address_generator #(.N_INPUTS(NI), .N_NEURONS(NN), .IN_W(8), .N_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .AG_rst(AG_rst), .AG_read(AG_read),
    .in_addr(in_addr), .w_addr(w_addr), .neuron_idx(neuron_idx),
    .addr_valid(addr_valid), .last_in(last_in), .last_neuron(last_neuron),
    .busy(busy), .done(done)
  );

  address_generator #(.N_INPUTS(1), .N_NEURONS(1), .IN_W(8), .N_W(8), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .AG_rst(AG_rst2), .AG_read(AG_read2),
    .in_addr(in_addr2), .w_addr(w_addr2), .neuron_idx(neuron_idx2),
    .addr_valid(addr_valid2), .last_in(last_in2), .last_neuron(last_neuron2),
    .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the layer is just a sequence of TOTAL beats; beat k addresses
  // input k%NI of neuron k/NI at weight k.
  int m_k = 0;
  int m_in = 0, m_n = 0, m_w = 0;
  int m_valid = 0, m_li = 0, m_ln = 0;

  always @(posedge clk) begin
    if (reset || AG_rst) begin
      m_k <= 0; m_in <= 0; m_n <= 0; m_w <= 0;
      m_valid <= 0; m_li <= 0; m_ln <= 0;
    end else if (AG_read && m_k < TOTAL) begin
      m_in    <= m_k % NI;
      m_n     <= m_k / NI;
      m_w     <= m_k;
      m_valid <= 1;
      m_li    <= int'((m_k % NI) == NI - 1);
      m_ln    <= int'((m_k / NI) == NN - 1);
      m_k     <= m_k + 1;
    end else begin
      m_valid <= 0; m_li <= 0; m_ln <= 0;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_addr",     int'(in_addr),     m_in);
      chk("neuron_idx",  int'(neuron_idx),  m_n);
      chk("w_addr",      int'(w_addr),      m_w);
      chk("addr_valid",  int'(addr_valid),  m_valid);
      chk("last_in",     int'(last_in),     m_li);
      chk("last_neuron", int'(last_neuron), m_ln);
      chk("done",        int'(done),        int'(m_k == TOTAL));
      chk("busy",        int'(busy),        int'(m_k > 0 && m_k < TOTAL));
    end
  end

  // Drive one cycle of inputs; returns at the negedge after the edge.
  task automatic step(input logic rd, input logic cl);
    AG_read = rd;
    AG_rst  = cl;
    @(negedge clk);
  endtask

  int nvalid;

  initial begin
    // Reset held with AG_read high for two cycles.
    reset = 1'b1; AG_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Full sweep with AG_read held high.
    nvalid = 0;
    for (int i = 0; i < TOTAL; i++) begin
      step(1'b1, 1'b0);
      if (addr_valid) nvalid++;
      chk("sweep_w_addr", int'(w_addr), i);
      if (i == 3 || i == 7) chk("sweep_last_in", int'(last_in), 1);
      if (i == 8) chk("sweep_last_neuron", int'(last_neuron), 1);
      if (i == 7) chk("sweep_last_neuron_lo", int'(last_neuron), 0);
    end
    chk("sweep_beats", nvalid, 12);
    chk("final_done", int'(done), 1);
    chk("final_valid", int'(addr_valid), 1);
    chk("final_last_in", int'(last_in), 1);
    chk("final_last_neuron", int'(last_neuron), 1);
    step(1'b0, 1'b0);
    chk("hold_valid", int'(addr_valid), 0);
    chk("hold_in", int'(in_addr), 3);
    chk("hold_n", int'(neuron_idx), 2);
    chk("hold_w", int'(w_addr), 11);

    // DONE ignores AG_read.
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (addr_valid) nvalid++;
    end
    chk("done_hold_beats", nvalid, 0);
    chk("done_hold_done", int'(done), 1);
    step(1'b0, 1'b1);
    chk("agrst_done", int'(done), 0);
    chk("agrst_busy", int'(busy), 0);

    // Stall mid-neuron.
    step(1'b1, 1'b0);
    chk("stall_first_busy", int'(busy), 1);
    step(1'b1, 1'b0);
    chk("stall_b1_w", int'(w_addr), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("stall_valid", int'(addr_valid), 0);
      chk("stall_in", int'(in_addr), 1);
      chk("stall_n", int'(neuron_idx), 0);
      chk("stall_w", int'(w_addr), 1);
    end
    step(1'b1, 1'b0);
    chk("resume_valid", int'(addr_valid), 1);
    chk("resume_w", int'(w_addr), 2);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("stall_total_done", int'(done), 1);
    chk("stall_total_w", int'(w_addr), 11);

    // Clear mid-sweep in the same cycle as AG_read.
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("pre_clear_w", int'(w_addr), 5);
    step(1'b1, 1'b1);
    chk("clear_valid", int'(addr_valid), 0);
    chk("clear_w", int'(w_addr), 0);
    chk("clear_busy", int'(busy), 0);
    step(1'b1, 1'b0);
    chk("restart_w", int'(w_addr), 0);
    chk("restart_valid", int'(addr_valid), 1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("restart_not_done", int'(done), 0);
    step(1'b1, 1'b0);
    chk("restart_done", int'(done), 1);
    chk("restart_final_w", int'(w_addr), 11);
    step(1'b0, 1'b0);

    // Single input, single neuron instance.
    AG_rst2 = 1'b1;
    @(negedge clk);
    chk("deg_clear_done", int'(done2), 0);
    AG_rst2 = 1'b0; AG_read2 = 1'b1;
    @(negedge clk);
    chk("deg_valid", int'(addr_valid2), 1);
    chk("deg_last_in", int'(last_in2), 1);
    chk("deg_last_neuron", int'(last_neuron2), 1);
    chk("deg_done", int'(done2), 1);
    chk("deg_busy", int'(busy2), 0);
    chk("deg_w", int'(w_addr2), 0);
    @(negedge clk);
    chk("deg_valid_after", int'(addr_valid2), 0);
    chk("deg_done_after", int'(done2), 1);
    chk("deg_busy_after", int'(busy2), 0);
    AG_read2 = 1'b0;

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
